// File: rtl/s_rle_pkg.sv
// s_rle_pkg
// Shared definitions for the status run-length monitor.
//   S_W        : width of the upstream status vector
//   DEF_CNT_W  : default run-length counter width
//   DEF_DEPTH  : default number of FIFO records
//   rle_rec_t  : one (code, run-length) record at the default counter width
package s_rle_pkg;

   localparam int S_W       = 3;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_DEPTH = 4;

   typedef struct packed {
      logic [S_W-1:0]       code;
      logic [DEF_CNT_W-1:0] run;
   } rle_rec_t;

endpackage

// File: rtl/rle_fifo.sv
// rle_fifo
// Small record FIFO between the run-length encoder and the trace reader.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, rec_in    : write request and record from the encoder
//   ready           : reader accepts the head record this cycle
//   head            : head record, zero while empty
//   valid           : head record present (not empty)
//   full, empty     : occupancy flags decoded from the count register
//   drop            : a push was refused because the FIFO was full with no pop
module rle_fifo #(
   parameter int DEPTH = 4,
   parameter int REC_W = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [REC_W-1:0] rec_in,
   input  logic             ready,
   output logic [REC_W-1:0] head,
   output logic             valid,
   output logic             full,
   output logic             empty,
   output logic             drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [REC_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W:0]   count;
   logic             pop;
   logic             wrEn;

   // A pop frees the slot the push needs, so a full FIFO can still accept a
   // record on an edge where the head leaves; only a push without a pop drops.
   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);
   assign valid = !empty;
   assign pop   = ready && !empty;
   assign wrEn  = push && (!full || pop);
   assign drop  = push && full && !pop;
   assign head  = empty ? '0 : mem[rdPtr];

   // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (wrEn) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (pop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         if (wrEn && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !wrEn) begin
            count <= count - 1'b1;
         end
      end
   end

   // Record storage needs no reset: the head is masked to zero while empty.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem[wrPtr] <= rec_in;
      end
   end

endmodule

// File: rtl/s_rle_monitor.sv
// s_rle_monitor
// Samples the 3-bit status vector every clock, run-length encodes it into
// (code, run) records and queues them for a slow reader.
// Ports:
//   CLK, RSTN             : clock, asynchronous active-low reset
//   S                     : status vector, sampled each rising edge
//   OUT_VALID, OUT_READY  : valid/ready handshake for the head record
//   OUT_CODE, OUT_RUN     : head record code and run length (1..2^CNT_W-1)
//   FULL, EMPTY           : FIFO occupancy flags
//   OVF                   : sticky, a record was dropped since reset
module s_rle_monitor
   import s_rle_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [S_W-1:0]   S,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [S_W-1:0]   OUT_CODE,
   output logic [CNT_W-1:0] OUT_RUN,
   output logic             FULL,
   output logic             EMPTY,
   output logic             OVF
);

   localparam int REC_W = S_W + CNT_W;
   localparam logic [CNT_W-1:0] RUN_MAX = '1;

   logic             primed;
   logic [S_W-1:0]   curCode;
   logic [CNT_W-1:0] run;
   logic             push;
   logic             drop;
   logic [REC_W-1:0] head;

   // The open run closes on a code change or when its counter saturates; a
   // saturated run is split and continues as a fresh run of the same code.
   assign push = primed && ((S != curCode) || (run == RUN_MAX));

   // Run tracking: the first edge after reset only captures the code.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         primed  <= 1'b0;
         curCode <= '0;
         run     <= '0;
      end else if (!primed) begin
         primed  <= 1'b1;
         curCode <= S;
         run     <= CNT_W'(1);
      end else if (push) begin
         curCode <= S;
         run     <= CNT_W'(1);
      end else begin
         run     <= run + 1'b1;
      end
   end

   // Drop history is sticky so the reader can tell the trace has a gap.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         OVF <= 1'b0;
      end else if (drop) begin
         OVF <= 1'b1;
      end
   end

   rle_fifo #(
      .DEPTH (DEPTH),
      .REC_W (REC_W)
   ) u_fifo (
      .clk    (CLK),
      .rst_n  (RSTN),
      .push   (push),
      .rec_in ({curCode, run}),
      .ready  (OUT_READY),
      .head   (head),
      .valid  (OUT_VALID),
      .full   (FULL),
      .empty  (EMPTY),
      .drop   (drop)
   );

   assign OUT_CODE = head[REC_W-1 -: S_W];
   assign OUT_RUN  = head[CNT_W-1:0];

endmodule

// File: doc/s_rle_monitor.md
# s_rle_monitor

Downstream consumer of the 3-bit status vector `S[2:0]` produced by the `TopLevel2807` datapath. Samples `S` every clock, run-length encodes it into (code, run-length) records, and buffers the records in a small FIFO. The FIFO drains over a valid/ready interface toward the trace/readout logic. Lets a slow reader observe every status transition without sampling at full clock rate.

## Interface
Parameters:
- `DEPTH`, 4 — FIFO entries; power of two, ≥ 2.
- `CNT_W`, 8 — run-length counter width; MAX = 2^CNT_W − 1.

Ports:
- `CLK`  in  1  — single clock; all state updates on rising edge.
- `RSTN`  in  1  — asynchronous, active-low reset.
- `S`  in  3  — status vector from the upstream stage; sampled every rising edge.
- `OUT_VALID`  out  1  — head record available (= not empty).
- `OUT_READY`  in  1  — reader accepts the head record this cycle.
- `OUT_CODE`  out  3  — head record status code.
- `OUT_RUN`  out  CNT_W  — head record run length in cycles, range 1..MAX.
- `FULL`  out  1  — FIFO holds DEPTH records.
- `EMPTY`  out  1  — FIFO holds 0 records.
- `OVF`  out  1  — sticky flag: a record was dropped; cleared only by reset.

## Operation
- Internal state:
  - `primed` (1b): first sample taken.
  - `cur_code` (3b): code of the open run.
  - `run` (CNT_W): length of the open run.
  - FIFO: write pointer, read pointer, count.
- Reset (`RSTN`=0, async):
  - `primed`=0, `cur_code`=0, `run`=0.
  - Pointers and count cleared, `OVF`=0.
  - Outputs: `OUT_VALID`=0, `OUT_CODE`=0, `OUT_RUN`=0, `FULL`=0, `EMPTY`=1.
- Per rising edge, with `RSTN`=1:
  - `primed`=0: `cur_code`←S, `run`←1, `primed`←1. No push.
  - `primed`=1, `S`==`cur_code` and `run`<MAX: `run`←`run`+1.
  - Otherwise (`S`≠`cur_code`, or `run`==MAX): push {`cur_code`, `run`}, then `cur_code`←S, `run`←1.
    - A saturated run splits into MAX-length records, continuing with `run`=1 on the same code.
- Pop: on an edge where `OUT_VALID`=1 and `OUT_READY`=1, the head is removed.
- Push while full:
  - Without a same-cycle pop: record discarded, `OVF`←1, FIFO contents unchanged.
  - With a same-cycle pop: the push succeeds, `OVF` is unaffected, count unchanged.
- Push and pop on the same edge when not full: count unchanged.
- Pop while empty is ignored; `OUT_READY` is a don't-care when `OUT_VALID`=0.
- The open run is never flushed spontaneously. It is emitted only at the next change or at saturation.
- Pointers wrap modulo DEPTH. `FULL` and `EMPTY` are derived from a count register that is ⌈log2(DEPTH)⌉+1 bits wide.

## Timing
- `OUT_CODE` and `OUT_RUN` are driven combinationally from the head entry (FIFO storage is registered).
- `OUT_VALID`, `FULL`, `EMPTY` and `OVF` are register outputs; there are no combinational paths from `S` or `OUT_READY` to any output.
- Latency:
  - `S` changes and is sampled at edge k: the record closing the previous run is written at edge k.
  - If the FIFO was empty, `OUT_VALID`=1 after edge k.
- Handshake:
  - `OUT_VALID` never drops without a pop.
  - The head is stable while `OUT_VALID`=1 and `OUT_READY`=0.
- Throughput: one push and one pop per cycle, sustained.
- Reset asserted mid-run or with a non-empty FIFO:
  - Everything is discarded immediately.
  - After release, the first edge re-primes and produces no record.

## Structure
- Shared package `s_rle_pkg`:
  - `S_W`=3.
  - Default `CNT_W` and `DEPTH`.
  - Record typedef `rle_rec_t` = {code[S_W], run[CNT_W]}.
- Sub-module `rle_fifo`: DEPTH × `rle_rec_t` storage, pointers, count, `FULL`/`EMPTY`, drop detection.
- Top level holds the priming logic, run counter, push decision and `OVF`.

## Test plan
- Reset, then hold `S`=3'b010 for 5 cycles, then `S`=3'b101 → exactly one record {010, 5}. `OUT_VALID` rises after the first 101 edge.
- `S` toggles 001/110 every cycle for 8 cycles with `OUT_READY`=1 → records alternate {001,1}/{110,1}. `FULL` never set, `OVF`=0.
- `CNT_W`=4, `S` constant 3'b111 for 40 cycles → records {111,15} and {111,15}; the open run holds 10.
- `OUT_READY`=0, 6 transitions with DEPTH=4:
  - `FULL`=1 after the 4th record; the 5th and 6th are dropped and `OVF`=1.
  - Then `OUT_READY`=1: the first 4 records drain in order and `EMPTY`=1.
- FIFO full, push and pop on the same edge → no drop, `OVF` stays 0, `FULL` stays 1, the new record appears at the tail.
- `RSTN` pulsed low mid-run with 2 records queued:
  - Outputs return to reset values asynchronously.
  - The first post-reset edge produces no record.
  - The next change yields a record whose run counts from the re-prime edge.
